// File: rtl/frame_serializer.sv
// ---------------------------------------------------------------------------
// frame_serializer
//
// Purpose:
//   Upstream feeder for the serial frame-error detector.  Parallel frames are
//   accepted over a valid/ready handshake into a small FIFO.  Frames are then
//   shifted out LSB first, one bit per Clock, on Dout.  Frame alignment is
//   continuous from reset.  Whenever the FIFO is empty at a frame boundary, an
//   idle frame (IDLE_WORD) is sent, so the detector never loses its frame
//   boundary.
//
// Parameters:
//   FRAME_LEN  bits per frame (>= 2), must match the detector
//   DEPTH      FIFO depth in frames (power of two, >= 2)
//   IDLE_WORD  filler frame sent when nothing is queued
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-low reset
//   Load_Valid   in   Load_Data holds a frame to enqueue
//   Load_Data    in   parallel frame, bit 0 transmitted first
//   Load_Ready   out  FIFO can accept a frame this cycle (Count != DEPTH)
//   Dout         out  serial bit to the detector's Din
//   Frame_Start  out  high while Dout carries bit 0 of a frame
//   Idle         out  high for every bit of an idle frame
//   Count        out  frames currently held in the FIFO
//
// Optional feature (macro FRAME_SERIALIZER_STATS_EN):
//   Stats_Clr    in   synchronous clear of both statistics counters
//   Frames_Sent  out  data frames started, wraps at 0xFFFF
//   Idle_Frames  out  idle frames started, saturates at 0xFFFF
// ---------------------------------------------------------------------------
module frame_serializer #(
  parameter int                   FRAME_LEN = 3,
  parameter int                   DEPTH     = 4,
  parameter logic [FRAME_LEN-1:0] IDLE_WORD = '0,
  localparam int                  CW        = $clog2(DEPTH + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Load_Valid,
  input  logic [FRAME_LEN-1:0] Load_Data,
  output logic                 Load_Ready,
  output logic                 Dout,
  output logic                 Frame_Start,
  output logic                 Idle,
`ifdef FRAME_SERIALIZER_STATS_EN
  input  logic                 Stats_Clr,
  output logic [15:0]          Frames_Sent,
  output logic [15:0]          Idle_Frames,
`endif
  output logic [CW-1:0]        Count
);

  localparam int             PW       = $clog2(DEPTH);
  localparam int             BW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0]  LAST_BIT = BW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]  FULL     = CW'(DEPTH);

  logic [FRAME_LEN-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]        rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]        count_q, count_nxt;
  logic [FRAME_LEN-1:0] shift_q, shift_nxt;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_nxt;
  logic                 frame_start_q, frame_start_nxt;
  logic                 idle_q, idle_nxt;
  logic                 boundary;
  logic                 push;
  logic                 pop;

  // Ready is judged on the count before the edge.  A full FIFO therefore
  // refuses a push even on an edge where a pop frees a slot.
  assign Load_Ready = (count_q != FULL);
  assign boundary   = (bit_cnt_q == LAST_BIT);
  assign push       = Load_Valid && Load_Ready;
  // The pop also uses the count before the edge.  A word pushed into an empty
  // FIFO on a boundary edge waits one frame, and an idle frame goes out first.
  assign pop        = boundary && (count_q != '0);

  assign Dout        = shift_q[0];
  assign Frame_Start = frame_start_q;
  assign Idle        = idle_q;
  assign Count       = count_q;

  // Next-state logic for the FIFO bookkeeping and the serial shifter.
  always_comb begin
    wr_ptr_nxt      = wr_ptr;
    rd_ptr_nxt      = rd_ptr;
    count_nxt       = count_q;
    shift_nxt       = shift_q;
    bit_cnt_nxt     = bit_cnt_q;
    frame_start_nxt = frame_start_q;
    idle_nxt        = idle_q;

    if (push) wr_ptr_nxt = wr_ptr + PW'(1);
    if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);

    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase

    if (boundary) begin
      bit_cnt_nxt     = '0;
      frame_start_nxt = 1'b1;
      if (pop) begin
        shift_nxt = mem[rd_ptr];
        idle_nxt  = 1'b0;
      end else begin
        shift_nxt = IDLE_WORD;
        idle_nxt  = 1'b1;
      end
    end else begin
      shift_nxt       = shift_q >> 1;
      bit_cnt_nxt     = bit_cnt_q + BW'(1);
      frame_start_nxt = 1'b0;
    end
  end

  // State register.  Reset places the shifter on bit 0 of an idle frame, the
  // same bit the detector's start state expects.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      shift_q       <= IDLE_WORD;
      bit_cnt_q     <= '0;
      frame_start_q <= 1'b1;
      idle_q        <= 1'b1;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      count_q       <= count_nxt;
      shift_q       <= shift_nxt;
      bit_cnt_q     <= bit_cnt_nxt;
      frame_start_q <= frame_start_nxt;
      idle_q        <= idle_nxt;
    end
  end

  // The storage array has no reset.  Resetting the pointers and the count
  // already discards everything it held.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= Load_Data;
  end

`ifdef FRAME_SERIALIZER_STATS_EN
  // Statistics counters.  A clear wins over an increment on the same edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Frames_Sent <= '0;
      Idle_Frames <= '0;
    end else if (Stats_Clr) begin
      Frames_Sent <= '0;
      Idle_Frames <= '0;
    end else begin
      if (pop) Frames_Sent <= Frames_Sent + 16'd1;
      if (boundary && !pop && (Idle_Frames != 16'hFFFF))
        Idle_Frames <= Idle_Frames + 16'd1;
    end
  end
`endif

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Upstream feeder for the serial frame-error detector.
- Accepts parallel frames through a valid/ready handshake and buffers them in a small FIFO.
- Shifts frames out one bit per Clock on Dout, which drives the detector's Din.
- Keeps frame alignment continuous from reset: when no data is queued, an idle frame is sent so the detector's frame boundary never drifts.

Parameters:
- FRAME_LEN, 3, bits per frame; must match the detector's frame length; legal range ≥2.
- DEPTH, 4, FIFO depth in frames; power of two, ≥2.
- IDLE_WORD, 3'b000, FRAME_LEN-bit filler frame sent when the FIFO is empty at a frame boundary.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Load_Valid  input  1  Load_Data holds a frame to enqueue.
- Load_Data  input  FRAME_LEN  parallel frame; bit 0 is transmitted first.
- Load_Ready  output  1  FIFO can accept a frame this cycle.
- Dout  output  1  serial bit to the detector's Din.
- Frame_Start  output  1  high while Dout carries bit 0 of a frame.
- Idle  output  1  high for every bit of an idle (filler) frame.
- Count  output  $clog2(DEPTH+1)  frames currently held in the FIFO.

Behaviour:
- Interface: one clock (Clock); Reset is asynchronous and active-low. All state is cleared immediately on Reset low, independent of Clock.
- Reset values:
  - FIFO empty, Count=0, Load_Ready=1.
  - Shift register = IDLE_WORD, bit counter = 0.
  - Dout = IDLE_WORD[0], Frame_Start=1, Idle=1.
- Alignment: reset is shared with the detector. After Reset release, the first rising edge starts the second bit of the reset idle frame. The detector's start state lines up with the bit presented during reset.
- Load_Ready = (Count != DEPTH), combinational from Count.
- Push occurs on a rising edge when Load_Valid && Load_Ready.
- Load_Valid while full is ignored; the source must hold Load_Valid and Load_Data until accepted.
- Dout, Frame_Start and Idle are registered outputs. Dout = shift register bit 0.
- Each rising edge, with bit counter < FRAME_LEN-1:
  - shift register shifts right by one;
  - bit counter increments;
  - Frame_Start=0; Idle holds.
- Each rising edge, with bit counter == FRAME_LEN-1 (frame boundary):
  - If Count>0: pop the FIFO head into the shift register, Idle=0.
  - Otherwise: load IDLE_WORD, Idle=1.
  - Bit counter=0, Frame_Start=1.
- Frame spacing: exactly one frame is emitted every FRAME_LEN cycles, with no gaps.
- Push and pop on the same edge:
  - Both occur; Count is unchanged.
  - A pop is decided on Count before the edge. A word pushed into an empty FIFO on a boundary edge is not popped; an idle frame is sent and the word goes out in the following frame.
  - A full FIFO does not accept a push even on a popping edge, because Load_Ready is based on Count before the edge.
- Latency: a word accepted at edge N goes out starting at the first frame boundary strictly after N at which it is at the FIFO head.
- Ordering: strictly FIFO; no frame is lost or duplicated.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count never exceeds DEPTH and never underflows.
- Reset low mid-frame: the partially sent frame and all queued frames are discarded and the reset values are restored at once. No residual bit appears after release.

Optional Feature:
- Macro: FRAME_SERIALIZER_STATS_EN.
- When defined, the block adds:
  - input Stats_Clr (1 bit), a synchronous clear;
  - output Frames_Sent (16 bits), incremented at each boundary that pops a data frame; wraps 0xFFFF→0;
  - output Idle_Frames (16 bits), incremented at each boundary that loads IDLE_WORD; saturates at 0xFFFF.
- Both counters reset to 0 on Reset and on Stats_Clr. Stats_Clr has priority over an increment on the same edge.
- When the macro is not defined, these ports and this logic are absent and the base behaviour is unchanged.

Test Plan:
- Hold Reset low, with FRAME_LEN=3, DEPTH=4, IDLE_WORD=000 -> Dout=0, Frame_Start=1, Idle=1, Load_Ready=1, Count=0; after release, Frame_Start pulses every 3rd cycle.
- Push 3'b011 mid-frame -> at the next boundary Dout=1,1,0 over three cycles, Frame_Start on the first, Idle=0 for all three, Count returns to 0; the next frame is idle 0,0,0.
- Burst-push 6 frames with Load_Valid held -> Load_Ready drops when Count=4; the remaining frames are accepted only as boundary pops free slots; the serial output order matches the push order exactly.
- Push into an empty FIFO on a boundary edge -> an idle frame is emitted first, then the pushed word; Count is 1 during the idle frame.
- Assert Reset for 1 ns during bit 1 of a data frame with 2 frames queued -> Dout=0, Frame_Start=1, Idle=1, Count=0 immediately; no queued data appears after release.
- With FRAME_SERIALIZER_STATS_EN defined: send 5 data and 3 idle frames -> Frames_Sent=5, Idle_Frames=3; pulse Stats_Clr on a boundary edge -> both read 0 afterwards.
